// File: rtl/sao_pkg.sv
// Shared types for the SAO LCU scheduler: size and type codes,
// the packed per-LCU parameter word and the frame-walk states.
package sao_pkg;

  localparam int LCU_COLS_MAX = 8;
  localparam int PRM_DEPTH = LCU_COLS_MAX * LCU_COLS_MAX;
  localparam int PRM_AW = 6;
  localparam int PRM_W = 24;

  typedef enum logic [1:0] {
    LCU_16 = 2'd0,
    LCU_32 = 2'd1,
    LCU_64 = 2'd2
  } lcu_size_e;

  typedef enum logic [1:0] {
    SAO_OFF  = 2'd0,
    SAO_BAND = 2'd1,
    SAO_EDGE = 2'd2
  } sao_type_e;

  localparam int OFS_TYPE = 22;
  localparam int OFS_BAND = 17;
  localparam int OFS_EO = 16;
  localparam int OFS_OFFSET = 0;

  typedef struct packed {
    logic [1:0]  sao_type;
    logic [4:0]  band_pos;
    logic        eo_class;
    logic [15:0] offset;
  } sao_prm_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_STREAM,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_e;

  // Size code 3 is not a real LCU size; fold it onto 64x64.
  function automatic logic [1:0] norm_size(
    input logic [1:0] s
  );
    return (s == 2'd3) ? 2'(LCU_64) : s;
  endfunction

endpackage

// File: rtl/sao_lcu_scheduler_if.sv
// Pixel ingress and SAO engine bus of the LCU scheduler.
// master = scheduler side, slave = upstream source / engine side.
interface sao_lcu_scheduler_if;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        eng_in_en;
  logic [7:0]  eng_din;
  logic [1:0]  eng_sao_type;
  logic [4:0]  eng_band_pos;
  logic        eng_eo_class;
  logic [15:0] eng_offset;
  logic [2:0]  eng_lcu_x;
  logic [2:0]  eng_lcu_y;
  logic [1:0]  eng_lcu_size;
  logic        eng_busy;

  modport master (
    input  pix_valid, pix_data, eng_busy,
    output pix_ready, eng_in_en, eng_din,
    output eng_sao_type, eng_band_pos,
    output eng_eo_class, eng_offset,
    output eng_lcu_x, eng_lcu_y, eng_lcu_size
  );

  modport slave (
    output pix_valid, pix_data, eng_busy,
    input  pix_ready, eng_in_en, eng_din,
    input  eng_sao_type, eng_band_pos,
    input  eng_eo_class, eng_offset,
    input  eng_lcu_x, eng_lcu_y, eng_lcu_size
  );
endinterface

// File: rtl/sao_param_ram.sv
// Per-LCU SAO parameter table: synchronous write, registered read.
// Contents survive reset on purpose.
module sao_param_ram
  import sao_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [PRM_AW-1:0] waddr,
  input  logic [PRM_W-1:0]  wdata,
  input  logic [PRM_AW-1:0] raddr,
  output logic [PRM_W-1:0]  rdata
);

  logic [PRM_W-1:0] mem [PRM_DEPTH];
  logic [PRM_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sao_lcu_scheduler.sv
// Walks a 128x128 frame LCU by LCU, feeding parameters and a
// gap-free pixel stream to the SAO engine.
module sao_lcu_scheduler
  import sao_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  cfg_lcu_size,
  input  logic        prm_we,
  input  logic [5:0]  prm_addr,
  input  logic [23:0] prm_wdata,
  sao_lcu_scheduler_if.master bus,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e      state_q, state_d;
  logic [2:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  size_q, size_d;
  logic [11:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        in_en_q, in_en_d;
  logic [7:0]  din_q, din_d;
  sao_prm_t    prm_q, prm_d;
  logic [2:0]  lcu_x_q, lcu_x_d;
  logic [2:0]  lcu_y_q, lcu_y_d;
  logic [1:0]  lcu_size_q, lcu_size_d;

  logic [23:0] rd_data;
  logic [5:0]  raddr;
  logic [2:0]  cols_m1;
  logic [11:0] last_cnt;

  assign cols_m1 = 3'd7 >> size_q;
  assign last_cnt = 12'hFFF >> (3'd4 - {size_q, 1'b0});
  assign raddr = ({3'b000, y_q} << (2'd3 - size_q))
               + {3'b000, x_q};

  sao_param_ram u_ram (
    .clk   (clk),
    .we    (prm_we && (state_q == S_IDLE)),
    .waddr (prm_addr),
    .wdata (prm_wdata),
    .raddr (raddr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    size_d = size_q;
    cnt_d = cnt_q;
    err_d = err_q;
    in_en_d = 1'b0;
    din_d = din_q;
    prm_d = prm_q;
    lcu_x_d = lcu_x_q;
    lcu_y_d = lcu_y_q;
    lcu_size_d = lcu_size_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          x_d = 3'd0;
          y_d = 3'd0;
          cnt_d = 12'd0;
          err_d = 1'b0;
          size_d = norm_size(cfg_lcu_size);
        end
      end
      S_LOAD: state_d = S_SETUP;
      S_SETUP: begin
        prm_d = '{
          sao_type: rd_data[OFS_TYPE +: 2],
          band_pos: rd_data[OFS_BAND +: 5],
          eo_class: rd_data[OFS_EO],
          offset:   rd_data[OFS_OFFSET +: 16]
        };
        lcu_x_d = x_q;
        lcu_y_d = y_q;
        lcu_size_d = size_q;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        // A bubble still consumes a pixel slot; the engine sees a hold.
        in_en_d = bus.pix_valid;
        if (bus.pix_valid) din_d = bus.pix_data;
        else err_d = 1'b1;
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == last_cnt) begin
          cnt_d = 12'd0;
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (bus.eng_busy) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!bus.eng_busy) begin
          state_d = S_LOAD;
          if (x_q != cols_m1) begin
            x_d = x_q + 3'd1;
          end else begin
            x_d = 3'd0;
            if (y_q == cols_m1) state_d = S_DONE;
            else y_d = y_q + 3'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q <= '0;
      y_q <= '0;
      size_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      in_en_q <= 1'b0;
      din_q <= '0;
      prm_q <= '0;
      lcu_x_q <= '0;
      lcu_y_q <= '0;
      lcu_size_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      size_q <= size_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      in_en_q <= in_en_d;
      din_q <= din_d;
      prm_q <= prm_d;
      lcu_x_q <= lcu_x_d;
      lcu_y_q <= lcu_y_d;
      lcu_size_q <= lcu_size_d;
    end
  end

  assign bus.pix_ready = (state_q == S_STREAM);
  assign bus.eng_in_en = in_en_q;
  assign bus.eng_din = din_q;
  assign bus.eng_sao_type = prm_q.sao_type;
  assign bus.eng_band_pos = prm_q.band_pos;
  assign bus.eng_eo_class = prm_q.eo_class;
  assign bus.eng_offset = prm_q.offset;
  assign bus.eng_lcu_x = lcu_x_q;
  assign bus.eng_lcu_y = lcu_y_q;
  assign bus.eng_lcu_size = lcu_size_q;

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);
  assign err = err_q;

endmodule

// File: tb/tb_sao_lcu_scheduler.sv
// Scoreboard bench for sao_lcu_scheduler: expected LCU descriptors
// and pixels are queued when driven and popped as the DUT emits them.
module tb_sao_lcu_scheduler;
  import sao_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  cfg_lcu_size;
  logic        prm_we;
  logic [5:0]  prm_addr;
  logic [23:0] prm_wdata;
  logic        busy, done, err;

  sao_lcu_scheduler_if bus();

  sao_lcu_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_lcu_size (cfg_lcu_size),
    .prm_we       (prm_we),
    .prm_addr     (prm_addr),
    .prm_wdata    (prm_wdata),
    .bus          (bus.master),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int done_exp = 0;
  logic        rdy_prev = 1'b0;
  logic [7:0]  pix_ctr = 8'd0;
  logic [7:0]  pixq [$];
  logic [31:0] lcuq [$];
  logic [23:0] prm_m [64];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] eng_vec();
    return {bus.eng_lcu_size, bus.eng_lcu_x, bus.eng_lcu_y,
            bus.eng_sao_type, bus.eng_band_pos,
            bus.eng_eo_class, bus.eng_offset};
  endfunction

  function automatic logic [31:0] lcu_exp(input int sz,
                                          input int x,
                                          input int y);
    int cols;
    logic [1:0] s;
    logic [2:0] xx, yy;
    cols = 8 >> sz;
    s = 2'(sz);
    xx = 3'(x);
    yy = 3'(y);
    return {s, xx, yy, prm_m[y * cols + x]};
  endfunction

  always @(negedge clk) begin
    if (bus.eng_in_en) begin
      en_cnt++;
      if (pixq.size() == 0)
        chk("pixq_empty", 32'(pixq.size()), 32'd1);
      else
        chk("pix", 32'(bus.eng_din), 32'(pixq.pop_front()));
    end
    if (bus.pix_ready && !rdy_prev) begin
      if (lcuq.size() == 0)
        chk("lcuq_empty", 32'(lcuq.size()), 32'd1);
      else
        chk("lcu", eng_vec(), lcuq.pop_front());
    end
    rdy_prev = bus.pix_ready;
    if (done) done_cnt++;
  end

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
  endtask

  task automatic run_frame(input logic [1:0] cfg,
                           input bit wr_at_start,
                           input int abort_lcu,
                           input int drop_lcu,
                           input int wr_lcu,
                           input int long_lcu,
                           input int slow_lcu);
    int sz, cols, nlcu, npix, w, hold;
    bit drop;
    logic [7:0] last_pix;
    sz = (cfg == 2'd3) ? 2 : int'(cfg);
    cols = 8 >> sz;
    nlcu = cols * cols;
    npix = (16 << sz) * (16 << sz);
    last_pix = 8'd0;
    cfg_lcu_size = cfg;
    start = 1'b1;
    if (wr_at_start) begin
      prm_we = 1'b1;
      prm_addr = 6'd3;
      prm_wdata = {2'd1, 5'd4, 1'b0, 16'h12F3};
      prm_m[3] = prm_wdata;
    end
    for (int l = 0; l < nlcu; l++)
      lcuq.push_back(lcu_exp(sz, l % cols, l / cols));
    @(posedge clk); #1;
    start = 1'b0;
    prm_we = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("err_clr", 32'(err), 32'd0);
    for (int l = 0; l < nlcu; l++) begin
      en_cnt = 0;
      w = 0;
      while (!bus.pix_ready && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      chk("lat", 32'(w), (l == 0) ? 32'd2 : 32'd3);
      if (!bus.pix_ready) begin
        $display("FAIL lcu_wait timeout lcu=%0d", l);
        finish_run();
        $fatal(1);
      end
      for (int i = 0; i < npix; i++) begin
        if (l == abort_lcu && i == 10) begin
          bus.pix_valid = 1'b0;
          reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0;
          chk("rst_abort",
              32'({bus.pix_ready, busy, done, bus.eng_in_en}),
              32'd0);
          lcuq.delete();
          pixq.delete();
          return;
        end
        drop = (l == drop_lcu) && (i == 100 || i == 101);
        if (i == npix - 1)
          chk("rdy_last", 32'(bus.pix_ready), 32'd1);
        bus.pix_valid = !drop;
        bus.pix_data = pix_ctr;
        if (!drop) begin
          pixq.push_back(pix_ctr);
          last_pix = pix_ctr;
          pix_ctr++;
        end
        if (l == wr_lcu && i == 5) begin
          prm_we = 1'b1;
          prm_addr = 6'd0;
          prm_wdata = 24'hABCDEF;
        end else begin
          prm_we = 1'b0;
        end
        @(posedge clk); #1;
        if (drop) begin
          chk("gap_en", 32'(bus.eng_in_en), 32'd0);
          chk("gap_din", 32'(bus.eng_din), 32'(last_pix));
        end
      end
      bus.pix_valid = 1'b0;
      prm_we = 1'b0;
      chk("rdy_off", 32'(bus.pix_ready), 32'd0);
      if (l == slow_lcu) begin
        repeat (3) begin
          @(posedge clk); #1;
        end
        chk("slow_hold", 32'({bus.pix_ready, busy}), 32'd1);
      end
      hold = (l == long_lcu) ? 1000 : 1;
      bus.eng_busy = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
      end
      if (l == long_lcu) begin
        chk("long_prm", eng_vec(),
            lcu_exp(sz, l % cols, l / cols));
        chk("long_idle", 32'({bus.pix_ready, busy}), 32'd1);
      end
      bus.eng_busy = 1'b0;
      chk("en_cnt", 32'(en_cnt),
          32'((l == drop_lcu) ? npix - 2 : npix));
      if (l == drop_lcu) chk("err_set", 32'(err), 32'd1);
      if (l == nlcu - 1) begin
        @(posedge clk); #1;
        chk("done_hi", 32'({done, busy}), 32'b10);
        done_exp++;
        @(posedge clk); #1;
        chk("done_lo", 32'(done), 32'd0);
        chk("err_end", 32'(err),
            (drop_lcu >= 0) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cfg_lcu_size = 2'd0;
    prm_we = 1'b0;
    prm_addr = 6'd0;
    prm_wdata = 24'd0;
    bus.pix_valid = 1'b0;
    bus.pix_data = 8'd0;
    bus.eng_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'({bus.pix_ready, bus.eng_in_en,
                        busy, done, err}), 32'd0);
    chk("rst_eng", eng_vec(), 32'd0);
    chk("rst_din", 32'(bus.eng_din), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      prm_we = 1'b1;
      prm_addr = 6'(i);
      prm_wdata = {2'd0, 5'(i), 1'(i), 16'(i * 257)};
      prm_m[i] = prm_wdata;
      @(posedge clk); #1;
    end
    prm_we = 1'b0;
    run_frame(2'd0, 1'b0, -1, -1, 0, -1, 10);
    run_frame(2'd3, 1'b1, -1, -1, -1, 1, -1);
    run_frame(2'd1, 1'b0, -1, 0, -1, -1, -1);
    run_frame(2'd0, 1'b0, 5, -1, -1, -1, -1);
    run_frame(2'd1, 1'b0, -1, -1, -1, -1, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_cnt", 32'(done_cnt), 32'(done_exp));
    chk("pixq_left", 32'(pixq.size()), 32'd0);
    chk("lcuq_left", 32'(lcuq.size()), 32'd0);
    finish_run();
    $finish;
  end

endmodule
